// File: rtl/pipe_rr_scheduler.sv
`default_nettype none
// pipe_rr_scheduler: round-robin arbiter feeding a stallable two-stage (A -> C) word pipe.
// Optional macro PIPE_RR_SCHED_CNT_EN adds xfer_cnt, an 8-bit wrapping output-handshake counter.
module pipe_rr_scheduler #(
   parameter int NREQ = 4,
   parameter int DW   = 4,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   output logic                 out_valid,
   output logic [DW-1:0]        out_data,
   output logic [IDW-1:0]       out_id,
   input  logic                 out_ready,
   output logic                 busy
`ifdef PIPE_RR_SCHED_CNT_EN
   ,
   output logic [7:0]           xfer_cnt
`endif
);

   generate
      if ((NREQ < 2) || (NREQ > 8) || ((2 ** IDW) < NREQ)) begin : g_param_check
         $error("pipe_rr_scheduler: need 2 <= NREQ <= 8 and 2**IDW >= NREQ");
      end
   endgenerate

   localparam logic [IDW-1:0] C_RR_RESET = IDW'(NREQ - 1);

   logic            a_valid_q, a_valid_d;
   logic [DW-1:0]   a_data_q,  a_data_d;
   logic [IDW-1:0]  a_id_q,    a_id_d;
   logic            c_valid_q, c_valid_d;
   logic [DW-1:0]   c_data_q,  c_data_d;
   logic [IDW-1:0]  c_id_q,    c_id_d;
   logic [IDW-1:0]  rr_ptr_q,  rr_ptr_d;

   logic            advance;
   logic            found;
   logic [NREQ-1:0] win;
   logic [IDW-1:0]  grant_id;
   logic [IDW-1:0]  idx;

   assign advance = !c_valid_q || out_ready;

   // Search starts just after the last grant and wraps, so rr_ptr itself is checked last.
   always_comb begin
      win      = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
         if (!found && req_valid[idx]) begin
            found      = 1'b1;
            win[idx]   = 1'b1;
            grant_id   = idx;
         end
      end
   end

   assign req_ready = (rst_n && advance) ? win : '0;

   always_comb begin
      a_valid_d = a_valid_q;
      a_data_d  = a_data_q;
      a_id_d    = a_id_q;
      c_valid_d = c_valid_q;
      c_data_d  = c_data_q;
      c_id_d    = c_id_q;
      rr_ptr_d  = rr_ptr_q;
      if (advance) begin
         c_valid_d = a_valid_q;
         c_data_d  = a_data_q;
         c_id_d    = a_id_q;
         a_valid_d = found;
         if (found) begin
            a_data_d = req_data[int'(grant_id)*DW +: DW];
            a_id_d   = grant_id;
            rr_ptr_d = grant_id;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_valid_q <= 1'b0;
         a_data_q  <= '0;
         a_id_q    <= '0;
         c_valid_q <= 1'b0;
         c_data_q  <= '0;
         c_id_q    <= '0;
         rr_ptr_q  <= C_RR_RESET;
      end else begin
         a_valid_q <= a_valid_d;
         a_data_q  <= a_data_d;
         a_id_q    <= a_id_d;
         c_valid_q <= c_valid_d;
         c_data_q  <= c_data_d;
         c_id_q    <= c_id_d;
         rr_ptr_q  <= rr_ptr_d;
      end
   end

   // Gated by rst_n so nothing appears valid while reset is held, even before the first edge.
   assign out_valid = rst_n && c_valid_q;
   assign out_data  = c_data_q;
   assign out_id    = c_id_q;
   assign busy      = rst_n && (a_valid_q || c_valid_q);

`ifdef PIPE_RR_SCHED_CNT_EN
   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (out_valid && out_ready) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign xfer_cnt = cnt_q;
`endif

endmodule
`default_nettype wire
